// File: rtl/rf_scoreboard_if.sv
// Issue-side and writeback-side signals of the register-file hazard scoreboard.
// The master is the issue/writeback pipeline; the slave is the scoreboard.
interface rf_scoreboard_if #(
  parameter int STALL_W = 32
);
  logic               i_issue_valid;
  logic               o_issue_ready;
  logic [4:0]         i_issue_rs1_raddr;
  logic               i_issue_rs1_used;
  logic [4:0]         i_issue_rs2_raddr;
  logic               i_issue_rs2_used;
  logic               i_issue_rd_wen;
  logic [4:0]         i_issue_rd_waddr;
  logic               i_rd_wen;
  logic [4:0]         i_rd_waddr;
  logic               i_flush;
  logic [31:0]        o_busy;
  logic [STALL_W-1:0] o_stall_cycles;
  logic               o_err;

  // Handshake: an instruction issues in any cycle where i_issue_valid and
  // o_issue_ready are both high; ready is combinational and may be high
  // while valid is low, and the issue stage must not wait for ready to
  // assert valid.
  modport master (
    output i_issue_valid, i_issue_rs1_raddr, i_issue_rs1_used,
           i_issue_rs2_raddr, i_issue_rs2_used, i_issue_rd_wen,
           i_issue_rd_waddr, i_rd_wen, i_rd_waddr, i_flush,
    input  o_issue_ready, o_busy, o_stall_cycles, o_err
  );

  modport slave (
    input  i_issue_valid, i_issue_rs1_raddr, i_issue_rs1_used,
           i_issue_rs2_raddr, i_issue_rs2_used, i_issue_rd_wen,
           i_issue_rd_waddr, i_rd_wen, i_rd_waddr, i_flush,
    output o_issue_ready, o_busy, o_stall_cycles, o_err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Issue-stage RAW/overflow hazard tracker: one pending-write counter per
// architectural register, plus a saturating stall counter and sticky underflow flag.
module rf_scoreboard #(
  parameter int CNT_W     = 2,
  parameter bit BYPASS_EN = 1'b1,
  parameter int STALL_W   = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  rf_scoreboard_if.slave sb
);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  logic [CNT_W-1:0]   cnt_q [32];
  logic [CNT_W-1:0]   cnt_d [32];
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;

  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
  logic             rs1_hazard, rs2_hazard, ovf_hazard;
  logic             ready, fire, underflow;

  always_comb begin
    rs1_cnt = cnt_q[sb.i_issue_rs1_raddr];
    rs2_cnt = cnt_q[sb.i_issue_rs2_raddr];
    rd_cnt  = cnt_q[sb.i_issue_rd_waddr];
    wb_cnt  = cnt_q[sb.i_rd_waddr];

    // A single outstanding write landing this very cycle can be bypassed.
    rs1_hazard = sb.i_issue_rs1_used && (sb.i_issue_rs1_raddr != 5'd0) && (rs1_cnt != '0)
                 && !(BYPASS_EN && (rs1_cnt == CNT_ONE) && sb.i_rd_wen
                      && (sb.i_rd_waddr == sb.i_issue_rs1_raddr));
    rs2_hazard = sb.i_issue_rs2_used && (sb.i_issue_rs2_raddr != 5'd0) && (rs2_cnt != '0)
                 && !(BYPASS_EN && (rs2_cnt == CNT_ONE) && sb.i_rd_wen
                      && (sb.i_rd_waddr == sb.i_issue_rs2_raddr));
    // Conservative: a same-cycle writeback does not free a saturated counter.
    ovf_hazard = sb.i_issue_rd_wen && (sb.i_issue_rd_waddr != 5'd0) && (rd_cnt == CNT_MAX);

    ready     = !sb.i_flush && !rs1_hazard && !rs2_hazard && !ovf_hazard;
    fire      = sb.i_issue_valid && ready;
    underflow = sb.i_rd_wen && (sb.i_rd_waddr != 5'd0) && (wb_cnt == '0);
  end

  always_comb begin
    logic inc_n;
    logic dec_n;
    inc_n    = 1'b0;
    dec_n    = 1'b0;
    cnt_d[0] = '0;
    for (int n = 1; n < 32; n++) begin
      inc_n    = fire && sb.i_issue_rd_wen && (sb.i_issue_rd_waddr == 5'(n));
      dec_n    = sb.i_rd_wen && (sb.i_rd_waddr == 5'(n)) && (cnt_q[n] != '0);
      cnt_d[n] = cnt_q[n];
      if (sb.i_flush)          cnt_d[n] = '0;
      else if (inc_n && !dec_n) cnt_d[n] = cnt_q[n] + CNT_ONE;
      else if (dec_n && !inc_n) cnt_d[n] = cnt_q[n] - CNT_ONE;
    end

    err_d   = err_q || underflow;
    stall_d = stall_q;
    if (sb.i_issue_valid && !ready && (stall_q != '1)) stall_d = stall_q + STALL_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < 32; n++) cnt_q[n] <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int n = 0; n < 32; n++) cnt_q[n] <= cnt_d[n];
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    sb.o_busy = '0;
    for (int n = 1; n < 32; n++) sb.o_busy[n] = (cnt_q[n] != '0);
  end

  assign sb.o_issue_ready  = ready;
  assign sb.o_stall_cycles = stall_q;
  assign sb.o_err          = err_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: a bypassing instance checked against a reference
// model with a queue of expected o_busy values, plus a non-bypassing twin.
module tb_rf_scoreboard;
  logic clk;
  logic rst;

  rf_scoreboard_if #(.STALL_W(32)) sb_if ();
  rf_scoreboard_if #(.STALL_W(32)) nb_if ();

  rf_scoreboard #(.CNT_W(2), .BYPASS_EN(1'b1), .STALL_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .sb(sb_if.slave)
  );
  rf_scoreboard #(.CNT_W(2), .BYPASS_EN(1'b0), .STALL_W(32)) dut_nb (
    .i_clk(clk), .i_rst(rst), .sb(nb_if.slave)
  );

  assign nb_if.i_issue_valid     = sb_if.i_issue_valid;
  assign nb_if.i_issue_rs1_raddr = sb_if.i_issue_rs1_raddr;
  assign nb_if.i_issue_rs1_used  = sb_if.i_issue_rs1_used;
  assign nb_if.i_issue_rs2_raddr = sb_if.i_issue_rs2_raddr;
  assign nb_if.i_issue_rs2_used  = sb_if.i_issue_rs2_used;
  assign nb_if.i_issue_rd_wen    = sb_if.i_issue_rd_wen;
  assign nb_if.i_issue_rd_waddr  = sb_if.i_issue_rd_waddr;
  assign nb_if.i_rd_wen          = sb_if.i_rd_wen;
  assign nb_if.i_rd_waddr        = sb_if.i_rd_waddr;
  assign nb_if.i_flush           = sb_if.i_flush;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model of the bypassing instance
  int          m_cnt [32];
  logic [31:0] m_stall;
  logic        m_err;
  logic [31:0] exp_q [$];
  int          n_checks;
  int          n_errors;

  function automatic logic model_ready();
    logic h1, h2, ovf;
    h1 = sb_if.i_issue_rs1_used && sb_if.i_issue_rs1_raddr != 0 && m_cnt[sb_if.i_issue_rs1_raddr] != 0
         && !(m_cnt[sb_if.i_issue_rs1_raddr] == 1 && sb_if.i_rd_wen && sb_if.i_rd_waddr == sb_if.i_issue_rs1_raddr);
    h2 = sb_if.i_issue_rs2_used && sb_if.i_issue_rs2_raddr != 0 && m_cnt[sb_if.i_issue_rs2_raddr] != 0
         && !(m_cnt[sb_if.i_issue_rs2_raddr] == 1 && sb_if.i_rd_wen && sb_if.i_rd_waddr == sb_if.i_issue_rs2_raddr);
    ovf = sb_if.i_issue_rd_wen && sb_if.i_issue_rd_waddr != 0 && m_cnt[sb_if.i_issue_rd_waddr] == 3;
    return !sb_if.i_flush && !h1 && !h2 && !ovf;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    for (int n = 1; n < 32; n++) b[n] = (m_cnt[n] != 0);
    return b;
  endfunction

  // one clock edge: advance the model and queue the expected o_busy
  task automatic tick();
    logic rdy, dec;
    rdy = model_ready();
    @(posedge clk);
    if (rst) begin
      for (int n = 0; n < 32; n++) m_cnt[n] = 0;
      m_stall = '0;
      m_err   = 1'b0;
    end else begin
      if (sb_if.i_issue_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (sb_if.i_rd_wen && sb_if.i_rd_waddr != 0 && m_cnt[sb_if.i_rd_waddr] == 0) m_err = 1'b1;
      if (sb_if.i_flush) begin
        for (int n = 0; n < 32; n++) m_cnt[n] = 0;
      end else begin
        dec = sb_if.i_rd_wen && sb_if.i_rd_waddr != 0 && m_cnt[sb_if.i_rd_waddr] != 0;
        if (dec) m_cnt[sb_if.i_rd_waddr] = m_cnt[sb_if.i_rd_waddr] - 1;
        if (sb_if.i_issue_valid && rdy && sb_if.i_issue_rd_wen && sb_if.i_issue_rd_waddr != 0)
          m_cnt[sb_if.i_issue_rd_waddr] = m_cnt[sb_if.i_issue_rd_waddr] + 1;
      end
    end
    exp_q.push_back(model_busy());
    #1;
  endtask

  // driver tasks
  task automatic set_idle();
    sb_if.i_issue_valid     = 1'b0;
    sb_if.i_issue_rs1_raddr = 5'd0;
    sb_if.i_issue_rs1_used  = 1'b0;
    sb_if.i_issue_rs2_raddr = 5'd0;
    sb_if.i_issue_rs2_used  = 1'b0;
    sb_if.i_issue_rd_wen    = 1'b0;
    sb_if.i_issue_rd_waddr  = 5'd0;
    sb_if.i_rd_wen          = 1'b0;
    sb_if.i_rd_waddr        = 5'd0;
    sb_if.i_flush           = 1'b0;
  endtask

  task automatic drive_issue(input logic v, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic rdw, input logic [4:0] rd);
    sb_if.i_issue_valid     = v;
    sb_if.i_issue_rs1_raddr = rs1;
    sb_if.i_issue_rs1_used  = u1;
    sb_if.i_issue_rs2_raddr = rs2;
    sb_if.i_issue_rs2_used  = u2;
    sb_if.i_issue_rd_wen    = rdw;
    sb_if.i_issue_rd_waddr  = rd;
  endtask

  task automatic drive_wb(input logic wen, input logic [4:0] waddr);
    sb_if.i_rd_wen   = wen;
    sb_if.i_rd_waddr = waddr;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (sb_if.o_busy !== e) begin n_errors++; $display("FAIL reset_busy: got %h expected %h", sb_if.o_busy, e); end
    n_checks++;
    if (sb_if.o_stall_cycles !== 32'd0) begin n_errors++; $display("FAIL reset_stall: got %0d expected 0", sb_if.o_stall_cycles); end
    n_checks++;
    if (sb_if.o_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", sb_if.o_err); end
    n_checks++;
    if (sb_if.o_issue_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", sb_if.o_issue_ready); end
  endtask

  task automatic test_issue_stall();
    logic [31:0] e;
    drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5);
    #1;
    n_checks++;
    if (sb_if.o_issue_ready !== 1'b1) begin n_errors++; $display("FAIL issue_rd5_ready: got %b expected 1", sb_if.o_issue_ready); end
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (sb_if.o_busy !== 32'h0000_0020 || e !== 32'h0000_0020) begin
      n_errors++; $display("FAIL issue_rd5_busy: got %h expected %h", sb_if.o_busy, 32'h0000_0020);
    end
    drive_issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_checks++;
      if (sb_if.o_issue_ready !== 1'b0) begin n_errors++; $display("FAIL raw_stall_ready: got %b expected 0", sb_if.o_issue_ready); end
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (sb_if.o_stall_cycles !== 32'(k) || sb_if.o_busy !== e) begin
        n_errors++; $display("FAIL raw_stall_count: got %0d/%h expected %0d/%h", sb_if.o_stall_cycles, sb_if.o_busy, k, e);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    drive_issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    drive_wb(1'b1, 5'd5);
    #1;
    n_checks++;
    if (sb_if.o_issue_ready !== 1'b1) begin n_errors++; $display("FAIL bypass_ready: got %b expected 1", sb_if.o_issue_ready); end
    n_checks++;
    if (nb_if.o_issue_ready !== 1'b0) begin n_errors++; $display("FAIL nobypass_ready: got %b expected 0", nb_if.o_issue_ready); end
    tick();
    drive_wb(1'b0, 5'd0);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (sb_if.o_busy[5] !== 1'b0 || sb_if.o_busy !== e) begin
      n_errors++; $display("FAIL bypass_busy: got %h expected %h", sb_if.o_busy, e);
    end
    n_checks++;
    if (nb_if.o_issue_ready !== 1'b1) begin n_errors++; $display("FAIL nobypass_next_ready: got %b expected 1", nb_if.o_issue_ready); end
    set_idle();
  endtask

  task automatic test_overflow();
    logic [31:0] e;
    drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7);
    for (int k = 0; k < 3; k++) begin
      tick();
      void'(exp_q.pop_front());
    end
    #1;
    n_checks++;
    if (sb_if.o_issue_ready !== 1'b0) begin n_errors++; $display("FAIL ovf_ready: got %b expected 0", sb_if.o_issue_ready); end
    drive_wb(1'b1, 5'd7);
    #1;
    n_checks++;
    if (sb_if.o_issue_ready !== 1'b0) begin n_errors++; $display("FAIL ovf_wb_ready: got %b expected 0", sb_if.o_issue_ready); end
    tick();
    drive_wb(1'b0, 5'd0);
    void'(exp_q.pop_front());
    #1;
    n_checks++;
    if (sb_if.o_issue_ready !== 1'b1) begin n_errors++; $display("FAIL ovf_after_wb_ready: got %b expected 1", sb_if.o_issue_ready); end
    tick();
    void'(exp_q.pop_front());
    set_idle();
    #1;
    n_checks++;
    if (m_cnt[7] != 3 || sb_if.o_busy[7] !== 1'b1) begin
      n_errors++; $display("FAIL ovf_cnt: got busy7=%b expected cnt 3 (model %0d)", sb_if.o_busy[7], m_cnt[7]);
    end
    drive_wb(1'b1, 5'd7);
    for (int k = 0; k < 3; k++) tick();
    drive_wb(1'b0, 5'd0);
    for (int k = 0; k < 2; k++) void'(exp_q.pop_front());
    e = exp_q.pop_front();
    n_checks++;
    if (sb_if.o_busy !== e || sb_if.o_err !== 1'b0) begin
      n_errors++; $display("FAIL ovf_drain: got %h/%b expected %h/0", sb_if.o_busy, sb_if.o_err, e);
    end
  endtask

  task automatic test_simultaneous();
    drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9);
    tick();
    void'(exp_q.pop_front());
    drive_wb(1'b1, 5'd9);
    #1;
    n_checks++;
    if (sb_if.o_issue_ready !== 1'b1) begin n_errors++; $display("FAIL simul_ready: got %b expected 1", sb_if.o_issue_ready); end
    tick();
    set_idle();
    void'(exp_q.pop_front());
    n_checks++;
    if (sb_if.o_busy[9] !== 1'b1 || sb_if.o_err !== 1'b0 || m_cnt[9] != 1) begin
      n_errors++; $display("FAIL simul_busy9: got busy9=%b err=%b expected 1/0", sb_if.o_busy[9], sb_if.o_err);
    end
    drive_wb(1'b1, 5'd9);
    tick();
    drive_wb(1'b0, 5'd0);
    n_checks++;
    if (sb_if.o_busy !== exp_q.pop_front()) begin n_errors++; $display("FAIL simul_drain: got %h expected 0", sb_if.o_busy); end
  endtask

  task automatic test_underflow();
    drive_wb(1'b1, 5'd12);
    tick();
    drive_wb(1'b0, 5'd0);
    void'(exp_q.pop_front());
    n_checks++;
    if (sb_if.o_err !== 1'b1 || sb_if.o_busy[12] !== 1'b0) begin
      n_errors++; $display("FAIL underflow_err: got err=%b busy12=%b expected 1/0", sb_if.o_err, sb_if.o_busy[12]);
    end
    tick();
    void'(exp_q.pop_front());
    n_checks++;
    if (sb_if.o_err !== 1'b1) begin n_errors++; $display("FAIL underflow_sticky: got %b expected 1", sb_if.o_err); end
    drive_wb(1'b1, 5'd0);
    drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0);
    tick();
    set_idle();
    n_checks++;
    if (sb_if.o_busy !== exp_q.pop_front() || sb_if.o_busy[0] !== 1'b0 || sb_if.o_err !== 1'b1) begin
      n_errors++; $display("FAIL wb_x0: got busy=%h err=%b expected 0/1", sb_if.o_busy, sb_if.o_err);
    end
    drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12);
    drive_wb(1'b1, 5'd12);
    tick();
    set_idle();
    n_checks++;
    if (sb_if.o_busy !== exp_q.pop_front() || sb_if.o_busy[12] !== 1'b1) begin
      n_errors++; $display("FAIL underflow_with_issue: got busy=%h expected bit12 set", sb_if.o_busy);
    end
  endtask

  task automatic test_flush_and_reset();
    logic [31:0] stall_before;
    drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3);
    tick(); tick();
    drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4);
    tick();
    for (int k = 0; k < 3; k++) void'(exp_q.pop_front());
    stall_before = sb_if.o_stall_cycles;
    sb_if.i_flush = 1'b1;
    #1;
    n_checks++;
    if (sb_if.o_issue_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b expected 0", sb_if.o_issue_ready); end
    tick();
    set_idle();
    void'(exp_q.pop_front());
    n_checks++;
    if (sb_if.o_busy !== 32'd0 || sb_if.o_stall_cycles !== stall_before + 32'd1) begin
      n_errors++; $display("FAIL flush_busy: got %h/%0d expected 0/%0d", sb_if.o_busy, sb_if.o_stall_cycles, stall_before + 1);
    end
    drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd6);
    tick();
    drive_issue(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) void'(exp_q.pop_front());
    n_checks++;
    if (sb_if.o_stall_cycles !== 32'd0 || sb_if.o_err !== 1'b0 || sb_if.o_busy !== exp_q.pop_front()) begin
      n_errors++; $display("FAIL midstall_reset: got stall=%0d err=%b busy=%h expected 0/0/0",
                           sb_if.o_stall_cycles, sb_if.o_err, sb_if.o_busy);
    end
    set_idle();
  endtask

  task automatic test_random();
    logic exp_rdy;
    logic [31:0] e;
    for (int i = 0; i < 300; i++) begin
      drive_issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      drive_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      sb_if.i_flush = ($urandom_range(0, 15) == 0);
      #1;
      exp_rdy = model_ready();
      n_checks++;
      if (sb_if.o_issue_ready !== exp_rdy) begin
        n_errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, sb_if.o_issue_ready, exp_rdy);
      end
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (sb_if.o_busy !== e || sb_if.o_stall_cycles !== m_stall || sb_if.o_err !== m_err) begin
        n_errors++; $display("FAIL rand_state[%0d]: got %h/%0d/%b expected %h/%0d/%b", i,
                             sb_if.o_busy, sb_if.o_stall_cycles, sb_if.o_err, e, m_stall, m_err);
      end
    end
    set_idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_stall  = '0;
    m_err    = 1'b0;
    for (int n = 0; n < 32; n++) m_cnt[n] = 0;
    rst = 1'b1;
    set_idle();
    #2;
    test_reset();
    test_issue_stall();
    test_bypass();
    test_overflow();
    test_simultaneous();
    test_underflow();
    test_flush_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Issue-stage hazard tracker sitting directly upstream of the register file (rf).
- Counts outstanding writes per architectural register: increments on instruction issue, decrements on writeback to the rf write port.
- Holds an instruction at issue (o_issue_ready low) until its source registers hold committed data, or until the data is forwardable through rf bypass.
- Also reports a stall-cycle performance counter and a sticky underflow error.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter; at most 2^CNT_W-1 writes may be outstanding to one register.
- BYPASS_EN, 1, must match the rf parameter. When 1, a writeback in the same cycle resolves a RAW hazard combinationally.
- STALL_W, 32, width of the stall-cycle counter.

Ports:
- i_clk  in  1  global clock.
- i_rst  in  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- i_issue_valid  in  1  issue stage presents an instruction.
- o_issue_ready  out  1  instruction may issue this cycle; issue fires when valid && ready.
- i_issue_rs1_raddr  in  5  source register 1 address.
- i_issue_rs1_used  in  1  instruction reads rs1.
- i_issue_rs2_raddr  in  5  source register 2 address.
- i_issue_rs2_used  in  1  instruction reads rs2.
- i_issue_rd_wen  in  1  instruction writes rd.
- i_issue_rd_waddr  in  5  destination register address.
- i_rd_wen  in  1  writeback enable; the same signal that drives the rf write port.
- i_rd_waddr  in  5  writeback address; the same signal that drives the rf write port.
- i_flush  in  1  discard all pending-write tracking.
- o_busy  out  32  bit n = 1 when counter n != 0. Bit 0 is always 0.
- o_stall_cycles  out  STALL_W  saturating count of cycles with valid && !ready.
- o_err  out  1  sticky flag: a writeback arrived for a register whose counter was 0.

Behaviour:
- State: 31 counters of CNT_W bits (x0 has no counter and reads as 0), the stall counter, and the err flag. All update on posedge i_clk.
- Reset (i_rst=1): all counters 0, o_stall_cycles 0, o_err 0. Reset takes priority over flush, issue and writeback in the same cycle. Reset mid-operation discards all tracking.
- o_busy is combinational from the counters.
- RAW hazard on rsN: rsN_used && rsN != 0 && cnt[rsN] != 0.
  - Exception when BYPASS_EN=1: no hazard if cnt[rsN] == 1 && i_rd_wen && i_rd_waddr == rsN.
  - When BYPASS_EN=0, a same-cycle writeback never clears the hazard; the instruction issues the following cycle.
- Overflow hazard: i_issue_rd_wen && rd != 0 && cnt[rd] == 2^CNT_W-1 (all ones).
  - If a writeback to rd arrives in the same cycle, this is still a hazard. The check is conservative and independent of BYPASS_EN.
- o_issue_ready = !i_flush && !rs1_hazard && !rs2_hazard && !overflow_hazard. It is combinational and depends on no other state.
  - Ready may be high while valid is low.
- Counter update for each n in 1..31:
  - inc = issue fired && i_issue_rd_wen && rd == n.
  - dec = i_rd_wen && i_rd_waddr == n && cnt[n] != 0.
  - inc only: +1. dec only: -1. Both: unchanged.
- Addresses of 0 never change any counter: issue with rd=0 and writeback to 0 are ignored, and never set o_err.
- Underflow: i_rd_wen && i_rd_waddr != 0 && cnt[i_rd_waddr] == 0 sets o_err = 1.
  - o_err is sticky until reset.
  - The counter stays 0.
  - If an issue to the same register fires in that cycle, its increment still applies.
- Flush: i_flush=1 zeroes all counters next cycle. Issue and writeback that cycle are ignored for counting, but the underflow check still applies.
- Stall counter: +1 per cycle in which i_issue_valid && !o_issue_ready, including flush cycles. It saturates at all ones and never wraps.
- Latency: hazard evaluation 0 cycles. A counter change is visible on o_busy / o_issue_ready in the cycle after the edge.

Test Plan:
- Reset, then issue rd=5 (wen=1, valid=1) → ready=1 that cycle; next cycle o_busy=32'h0000_0020. Then instruction rs1=5 → ready=0, o_stall_cycles increments each cycle.
- BYPASS_EN=1: cnt[5]=1, present rs1=5 together with i_rd_wen=1, i_rd_waddr=5 → ready=1 the same cycle; next cycle o_busy[5]=0. Repeat with BYPASS_EN=0 → ready=0 that cycle, 1 the next.
- Issue rd=7 three times (CNT_W=2) → cnt=3, fourth issue to rd=7 → ready=0. One writeback to 7 → fourth issues the next cycle, cnt stays 3.
- Simultaneous issue rd=9 and writeback 9 with cnt[9]=1 → cnt stays 1, o_busy[9]=1, o_err=0.
- Writeback to 12 with cnt[12]=0 → o_err=1 and remains 1. Writeback to 0 → o_err unchanged, o_busy[0]=0.
- cnt[3]=2, cnt[4]=1, pulse i_flush with valid=1 → ready=0 that cycle, o_busy=0 next cycle. Assert i_rst mid-stall → o_stall_cycles=0, o_err=0.
